progmem_fetcher: RTL and testbench

PROGMEM_FETCHER -- requirements
Module: progmem_fetcher

---
 rtl/progmem_fetcher.sv | 111 +++++++++++
 tb/tb_progmem_fetcher.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/progmem_fetcher.sv
// progmem_fetcher: streams word_count words from a program-memory read master into a FWFT FIFO.
// Optional feature macro: PROGMEM_FETCH_RESP_CHECK_EN (flags non-zero read responses on error).
module progmem_fetcher #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic [10:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [9:0]  mst_address,
    output logic        mst_read,
    input  logic [31:0] mst_readdata,
    input  logic [1:0]  mst_response,
    input  logic        mst_waitrequest,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, GAP, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [10:0]    remaining;
    logic [31:0]    mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           full, empty, accept, xfer, pop, finish;

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign accept    = (state == IDLE) && start && !done;
    assign mst_read  = (state == REQ) && !full;
    assign xfer      = mst_read && !mst_waitrequest;
    assign pop       = out_valid && out_ready;
    assign finish    = (state == DRAIN) && empty;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one read per REQ visit, a mandatory idle GAP cycle, then drain the FIFO
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (word_count == 11'd0) ? DRAIN : REQ;
            REQ:     if (xfer) state_nxt = GAP;
            GAP:     state_nxt = (remaining == 11'd0) ? DRAIN : REQ;
            DRAIN:   if (empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch bookkeeping: address (wraps naturally at 1024), remaining count, busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_address <= '0;
            remaining   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                mst_address <= base_addr;
                remaining   <= word_count;
                busy        <= 1'b1;
            end else if (xfer) begin
                mst_address <= mst_address + 10'd1;
                remaining   <= remaining - 11'd1;
            end
            if (finish) busy <= 1'b0;
        end
    end

    // FIFO pointers; reads are only issued with a free slot, so a push never overflows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (xfer) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are masked by out_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (xfer) mem[wr_ptr[AW-1:0]] <= mst_readdata;
    end

`ifdef PROGMEM_FETCH_RESP_CHECK_EN
    // Sticky response error, cleared only by the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           error <= 1'b0;
        else if (accept)                      error <= 1'b0;
        else if (xfer && mst_response != 2'd0) error <= 1'b1;
    end
`else
    logic unused_resp;
    assign unused_resp = ^mst_response;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_progmem_fetcher.sv
// tb_progmem_fetcher: directed self-checking bench for progmem_fetcher.
module tb_progmem_fetcher;
`ifdef PROGMEM_FETCH_RESP_CHECK_EN
    localparam logic RESP_EN = 1'b1;
`else
    localparam logic RESP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] word_count = '0;
    logic        busy, done, error;
    logic [9:0]  mst_address;
    logic        mst_read;
    logic [31:0] mst_readdata;
    logic [1:0]  mst_response;
    logic        mst_waitrequest;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    int         stall = 1;
    logic       err_en = 1'b0;
    logic [9:0] err_addr = '0;
    logic [7:0] wcnt;

    logic [9:0]  addr_q[$];
    logic [31:0] word_q[$];
    int   done_cnt = 0, read_cycles = 0, b2b_viol = 0, stall_viol = 0;
    logic prev_xfer = 1'b0, prev_stall = 1'b0;
    logic [9:0] prev_addr = '0;

    progmem_fetcher #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .mst_address(mst_address), .mst_read(mst_read), .mst_readdata(mst_readdata),
        .mst_response(mst_response), .mst_waitrequest(mst_waitrequest),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Slave model: stall cycles per transfer, data derived from address
    assign mst_waitrequest = !(mst_read && int'(wcnt) >= stall);
    assign mst_readdata    = 32'hC0DE_0000 | {22'd0, mst_address};
    assign mst_response    = (err_en && mst_address == err_addr) ? 2'd2 : 2'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        wcnt <= '0;
        else if (mst_read) wcnt <= mst_waitrequest ? wcnt + 8'd1 : 8'd0;
        else               wcnt <= '0;
    end

    // Mid-cycle monitor collecting transfers, delivered words and protocol violations
    always @(negedge clk) begin
        if (mst_read) read_cycles++;
        if (prev_xfer && mst_read) b2b_viol++;
        if (rst_n && prev_stall && mst_address != prev_addr) stall_viol++;
        if (mst_read && !mst_waitrequest) addr_q.push_back(mst_address);
        if (out_valid && out_ready) word_q.push_back(out_data);
        if (done) done_cnt++;
        prev_xfer  = mst_read && !mst_waitrequest;
        prev_stall = rst_n && mst_read && mst_waitrequest;
        prev_addr  = mst_address;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [9:0] b, input logic [10:0] wc);
        base_addr  = b;
        word_count = wc;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy, done, error, mst_read, out_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {busy, done, error, mst_read, out_valid});
        end
        checks++;
        if (mst_address !== 10'd0) begin
            errors++;
            $display("FAIL reset_addr got %h exp 000", mst_address);
        end
        checks++;
        if (out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        bit ok;
        int b0;
        b0 = b2b_viol;
        stall = 1;
        addr_q.delete();
        word_q.delete();
        do_start(10'h010, 11'd4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b exp 1", busy);
        end
        @(posedge clk); #1;
        base_addr  = 10'h200;
        word_count = 11'd2;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        wait_done(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done got timeout exp pulse");
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_at_done got %b exp 0", busy);
        end
        checks++;
        if (addr_q.size() != 4 || word_q.size() != 4) begin
            errors++;
            $display("FAIL basic_counts got %0d/%0d exp 4/4", addr_q.size(), word_q.size());
        end
        for (int i = 0; i < 4 && i < addr_q.size() && i < word_q.size(); i++) begin
            checks++;
            if (addr_q[i] !== 10'h010 + 10'(i) || word_q[i] !== (32'hC0DE_0010 + 32'(i))) begin
                errors++;
                $display("FAIL basic_item[%0d] got %h/%h exp %h/%h", i, addr_q[i], word_q[i],
                         10'h010 + 10'(i), 32'hC0DE_0010 + 32'(i));
            end
        end
        checks++;
        if (b2b_viol != b0) begin
            errors++;
            $display("FAIL basic_gap got %0d exp %0d", b2b_viol, b0);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        stall = 1;
        out_ready = 1'b0;
        addr_q.delete();
        word_q.delete();
        do_start(10'h100, 11'd8);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (addr_q.size() != 4 || mst_read !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got reads=%0d mst_read=%b exp 4/0", addr_q.size(), mst_read);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hC0DE_0100) begin
            errors++;
            $display("FAIL bp_head got %b/%h exp 1/c0de0100", out_valid, out_data);
        end
        out_ready = 1'b1;
        wait_done(400, ok);
        checks++;
        if (!ok || word_q.size() != 8) begin
            errors++;
            $display("FAIL bp_done got ok=%b words=%0d exp 1/8", ok, word_q.size());
        end
        for (int i = 0; i < 8 && i < word_q.size(); i++) begin
            checks++;
            if (word_q[i] !== 32'hC0DE_0100 + 32'(i)) begin
                errors++;
                $display("FAIL bp_word[%0d] got %h exp %h", i, word_q[i], 32'hC0DE_0100 + 32'(i));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        bit ok;
        logic [9:0] ea [3];
        ea[0] = 10'h3FE;
        ea[1] = 10'h3FF;
        ea[2] = 10'h000;
        addr_q.delete();
        word_q.delete();
        do_start(10'h3FE, 11'd3);
        wait_done(200, ok);
        checks++;
        if (!ok || addr_q.size() != 3 || word_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_count got ok=%b %0d/%0d exp 1/3/3", ok, addr_q.size(), word_q.size());
        end
        for (int i = 0; i < 3 && i < addr_q.size() && i < word_q.size(); i++) begin
            checks++;
            if (addr_q[i] !== ea[i] || word_q[i] !== (32'hC0DE_0000 | {22'd0, ea[i]})) begin
                errors++;
                $display("FAIL wrap_item[%0d] got %h/%h exp %h", i, addr_q[i], word_q[i], ea[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int r0;
        r0 = read_cycles;
        do_start(10'h155, 11'd0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_c1 got done=%b busy=%b exp 0/1", done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_c2 got done=%b busy=%b exp 1/0", done, busy);
        end
        base_addr  = 10'h055;
        word_count = 11'd5;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_start_on_done got done=%b busy=%b exp 0/0", done, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (read_cycles != r0) begin
            errors++;
            $display("FAIL zero_reads got %0d exp %0d", read_cycles - r0, 0);
        end
    endtask

    task automatic test_stall_reset;
        bit ok;
        int d0, s0;
        d0 = done_cnt;
        s0 = stall_viol;
        stall = 5;
        do_start(10'h020, 11'd6);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mst_read && !mst_waitrequest && mst_address == 10'h021) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_second got timeout exp transfer");
        end
        checks++;
        if (stall_viol != s0) begin
            errors++;
            $display("FAIL stall_addr_stable got %0d exp 0", stall_viol - s0);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, error, mst_read, out_valid} !== 5'b0 || mst_address !== 10'd0 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL stall_reset got %b %h %h exp 0", {busy, done, error, mst_read, out_valid},
                     mst_address, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stall = 1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_done got dones=%0d busy=%b valid=%b exp 0/0/0", done_cnt - d0, busy, out_valid);
        end
    endtask

    task automatic test_resp;
        bit ok;
        addr_q.delete();
        word_q.delete();
        stall = 1;
        err_en = 1'b1;
        err_addr = 10'h052;
        do_start(10'h050, 11'd4);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL resp_initial got %b exp 0", error);
        end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mst_read && !mst_waitrequest && mst_address == 10'h052) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (!ok || error !== RESP_EN) begin
            errors++;
            $display("FAIL resp_set got ok=%b err=%b exp 1/%b", ok, error, RESP_EN);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || word_q.size() != 4 || error !== RESP_EN) begin
            errors++;
            $display("FAIL resp_done got ok=%b words=%0d err=%b exp 1/4/%b", ok, word_q.size(), error, RESP_EN);
        end
        for (int i = 0; i < 4 && i < word_q.size(); i++) begin
            checks++;
            if (word_q[i] !== 32'hC0DE_0050 + 32'(i)) begin
                errors++;
                $display("FAIL resp_word[%0d] got %h exp %h", i, word_q[i], 32'hC0DE_0050 + 32'(i));
            end
        end
        err_en = 1'b0;
        @(posedge clk); #1;
        do_start(10'h060, 11'd1);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL resp_clear got %b exp 0", error);
        end
        wait_done(200, ok);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_stall_reset();
        test_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
